branch_predictor_btb: RTL and testbench



---
 rtl/bp_pkg.sv | 11 +
 rtl/bp_sat_counter.sv | 20 ++
 rtl/branch_predictor_btb.sv | 141 ++++++++++++++
 tb/tb_branch_predictor_btb.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: 2-bit direction counter and its encodings.
package bp_pkg;

  typedef logic [1:0] bp_ctr_t;

  localparam bp_ctr_t CTR_SNT = 2'b00;  // strongly not-taken
  localparam bp_ctr_t CTR_WNT = 2'b01;  // weakly not-taken
  localparam bp_ctr_t CTR_WT  = 2'b10;  // weakly taken
  localparam bp_ctr_t CTR_ST  = 2'b11;  // strongly taken

endpackage

// File: rtl/bp_sat_counter.sv
// Pure 2-bit saturating counter next-state function used on the training path.
module bp_sat_counter
  import bp_pkg::*;
(
  input  bp_ctr_t ctr_i,
  input  logic    taken_i,
  output bp_ctr_t ctr_o
);

  // Step towards taken/not-taken, holding at the extremes.
  always_comb begin
    ctr_o = ctr_i;
    if (taken_i && (ctr_i != CTR_ST)) begin
      ctr_o = ctr_i + 2'd1;
    end else if (!taken_i && (ctr_i != CTR_SNT)) begin
      ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Zero-latency lookup for IF, training and mispredict redirect from ID.
// Optional build macro BRANCH_PREDICTOR_STATS_EN adds saturating branch/mispredict counters.
module branch_predictor_btb
  import bp_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned TAG_W   = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] lk_pc_i,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_target_i,
  input  logic            upd_pred_taken_i,
  input  logic [XLEN-1:0] upd_pred_target_i,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o,
  input  logic            flush_i
`ifdef BRANCH_PREDICTOR_STATS_EN
  ,
  output logic [31:0]     stat_branches_o,
  output logic [31:0]     stat_mispredicts_o
`endif
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam logic [XLEN-1:0] PcStep = XLEN'(4);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [XLEN-1:0]    target_d [ENTRIES];
  bp_ctr_t            ctr_q    [ENTRIES];
  bp_ctr_t            ctr_d    [ENTRIES];

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             lk_hit, upd_hit;
  bp_ctr_t          ctr_trained;

  assign lk_idx  = lk_pc_i[IDX_W+1:2];
  assign lk_tag  = lk_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_idx = upd_pc_i[IDX_W+1:2];
  assign upd_tag = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];

  // Lookup: sees registered contents only, so same-cycle updates are not bypassed.
  always_comb begin
    lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken_o  = lk_hit && ctr_q[lk_idx][1];
    pred_target_o = pred_taken_o ? target_q[lk_idx] : lk_pc_i + PcStep;
  end

  // Redirect depends only on the resolved branch and what was predicted for it.
  always_comb begin
    redirect_o    = upd_valid_i && ((upd_taken_i != upd_pred_taken_i) ||
                                    (upd_taken_i && (upd_target_i != upd_pred_target_i)));
    redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + PcStep;
  end

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  bp_sat_counter u_sat_counter (
    .ctr_i   (ctr_q[upd_idx]),
    .taken_i (upd_taken_i),
    .ctr_o   (ctr_trained)
  );

  // Table next state: flush beats training; misses allocate only when taken.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (flush_i) begin
      valid_d = '0;
    end else if (upd_valid_i) begin
      if (upd_hit) begin
        ctr_d[upd_idx] = ctr_trained;
        if (upd_taken_i) begin
          target_d[upd_idx] = upd_target_i;
        end
      end else if (upd_taken_i) begin
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = upd_target_i;
        ctr_d[upd_idx]    = CTR_WT;
      end
    end
  end

  // Table storage, cleared asynchronously to empty/weakly-not-taken.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] stat_br_q, stat_br_d, stat_mp_q, stat_mp_d;

  // Saturating event counters; flush leaves them alone.
  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (upd_valid_i && (stat_br_q != '1)) stat_br_d = stat_br_q + 32'd1;
    if (redirect_o && (stat_mp_q != '1))  stat_mp_d = stat_mp_q + 32'd1;
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign stat_branches_o    = stat_br_q;
  assign stat_mispredicts_o = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Self-checking bench for branch_predictor_btb: directed scenarios plus randomized
// traffic compared against a behavioural table model.
module tb_branch_predictor_btb;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] lk_pc_i = '0;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        upd_valid_i = 1'b0;
  logic [31:0] upd_pc_i = '0;
  logic        upd_taken_i = 1'b0;
  logic [31:0] upd_target_i = '0;
  logic        upd_pred_taken_i = 1'b0;
  logic [31:0] upd_pred_target_i = '0;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        flush_i = 1'b0;
`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] stat_branches_o;
  logic [31:0] stat_mispredicts_o;
`endif

  branch_predictor_btb #(
    .XLEN    (32),
    .ENTRIES (16),
    .TAG_W   (8)
  ) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .lk_pc_i           (lk_pc_i),
    .pred_taken_o      (pred_taken_o),
    .pred_target_o     (pred_target_o),
    .upd_valid_i       (upd_valid_i),
    .upd_pc_i          (upd_pc_i),
    .upd_taken_i       (upd_taken_i),
    .upd_target_i      (upd_target_i),
    .upd_pred_taken_i  (upd_pred_taken_i),
    .upd_pred_target_i (upd_pred_target_i),
    .redirect_o        (redirect_o),
    .redirect_pc_o     (redirect_pc_o),
    .flush_i           (flush_i)
`ifdef BRANCH_PREDICTOR_STATS_EN
    ,
    .stat_branches_o   (stat_branches_o),
    .stat_mispredicts_o(stat_mispredicts_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural model: one slot per index, counter kept as an integer 0..3.
  bit          m_valid [16];
  int          m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  longint      m_br, m_mp;

  function automatic int pc_idx(input logic [31:0] pc);
    return int'((pc >> 2) % 32'd16);
  endfunction

  function automatic int pc_tag(input logic [31:0] pc);
    return int'((pc >> 6) % 32'd256);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
      m_tgt[i]   = '0;
      m_ctr[i]   = 1;
    end
    m_br = 0;
    m_mp = 0;
  endfunction

  function automatic void model_lookup(input logic [31:0] pc, output logic taken,
                                       output logic [31:0] tgt);
    int i;
    i = pc_idx(pc);
    taken = m_valid[i] && (m_tag[i] == pc_tag(pc)) && (m_ctr[i] >= 2);
    tgt   = taken ? m_tgt[i] : pc + 32'd4;
  endfunction

  function automatic void model_update(input logic uv, input logic [31:0] pc, input logic tk,
                                       input logic [31:0] tgt, input logic fl, input logic mp);
    int i;
    if (uv && m_br < 64'hFFFF_FFFF) m_br++;
    if (mp && m_mp < 64'hFFFF_FFFF) m_mp++;
    i = pc_idx(pc);
    if (fl) begin
      for (int k = 0; k < 16; k++) m_valid[k] = 1'b0;
    end else if (uv) begin
      if (m_valid[i] && m_tag[i] == pc_tag(pc)) begin
        if (tk) begin
          m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
          m_tgt[i] = tgt;
        end else begin
          m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (tk) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = pc_tag(pc);
        m_tgt[i]   = tgt;
        m_ctr[i]   = 2;
      end
    end
  endfunction

  // One clock: drive, check combinational outputs against the model, then clock and train.
  task automatic cycle(input logic [31:0] lk, input logic uv, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utgt, input logic upt,
                       input logic [31:0] uptgt, input logic fl);
    logic        et;
    logic [31:0] etgt;
    logic        emp;
    lk_pc_i = lk; upd_valid_i = uv; upd_pc_i = upc; upd_taken_i = ut;
    upd_target_i = utgt; upd_pred_taken_i = upt; upd_pred_target_i = uptgt; flush_i = fl;
    #1;
    model_lookup(lk, et, etgt);
    emp = uv && ((ut != upt) || (ut && (utgt != uptgt)));
    check("pred_taken", {31'd0, pred_taken_o}, {31'd0, et});
    check("pred_target", pred_target_o, etgt);
    check("redirect", {31'd0, redirect_o}, {31'd0, emp});
    check("redirect_pc", redirect_pc_o, ut ? utgt : upc + 32'd4);
`ifdef BRANCH_PREDICTOR_STATS_EN
    check("stat_branches", stat_branches_o, m_br[31:0]);
    check("stat_mispredicts", stat_mispredicts_o, m_mp[31:0]);
`endif
    @(posedge clk_i);
    model_update(uv, upc, ut, utgt, fl, emp);
    #1;
    upd_valid_i = 1'b0;
    flush_i     = 1'b0;
  endtask

  // Directed lookup against constant expectations (no training).
  task automatic lookup(input string tag, input logic [31:0] lk, input logic exp_t,
                        input logic [31:0] exp_tgt);
    lk_pc_i = lk; upd_valid_i = 1'b0; flush_i = 1'b0;
    #1;
    check({tag, "_taken"}, {31'd0, pred_taken_o}, {31'd0, exp_t});
    check({tag, "_target"}, pred_target_o, exp_tgt);
    @(posedge clk_i);
    #1;
  endtask

  // Asynchronous reset raised mid-cycle while an allocating update is presented.
  task automatic do_reset(input logic [31:0] lk);
    lk_pc_i = lk; upd_valid_i = 1'b1; upd_pc_i = lk; upd_taken_i = 1'b1;
    upd_target_i = 32'h0000_1234; flush_i = 1'b0;
    #1;
    rst_i = 1'b1;
    #1;
    check("rst_taken", {31'd0, pred_taken_o}, 32'd0);
    check("rst_target", pred_target_o, lk + 32'd4);
`ifdef BRANCH_PREDICTOR_STATS_EN
    check("rst_stat_br", stat_branches_o, 32'd0);
    check("rst_stat_mp", stat_mispredicts_o, 32'd0);
`endif
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    upd_valid_i = 1'b0;
    model_reset();
    #1;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] pc;
    pc = ($urandom & 32'h8000_0000) | (32'($urandom_range(0, 3)) << 6) |
         (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
    return pc;
  endfunction

  initial begin
    logic [31:0] lk, upc, utgt, uptgt;
    logic        ut, upt, uv, fl;

    model_reset();
    // Cold start while reset is held.
    lk_pc_i = 32'h40;
    #2;
    check("cold_taken", {31'd0, pred_taken_o}, 32'd0);
    check("cold_target", pred_target_o, 32'h44);
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;

    lookup("cold", 32'h40, 1'b0, 32'h44);
    lookup("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

    // Allocation with redirect, then counter walk.
    cycle(32'h40, 1'b1, 32'h40, 1'b1, 32'h20, 1'b0, 32'h44, 1'b0);
    lookup("alloc", 32'h40, 1'b1, 32'h20);
    cycle(32'h0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h20, 1'b0);
    lookup("wnt", 32'h40, 1'b0, 32'h44);
    cycle(32'h0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h44, 1'b0);
    cycle(32'h0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h44, 1'b0);
    lookup("snt", 32'h40, 1'b0, 32'h44);
    cycle(32'h0, 1'b1, 32'h40, 1'b1, 32'h20, 1'b0, 32'h44, 1'b0);
    lookup("snt_up", 32'h40, 1'b0, 32'h44);

    // Aliasing on index 0.
    cycle(32'h0, 1'b1, 32'h440, 1'b1, 32'h100, 1'b0, 32'h444, 1'b0);
    lookup("alias_old", 32'h40, 1'b0, 32'h44);
    lookup("alias_new", 32'h440, 1'b1, 32'h100);

    // Same-cycle lookup/update: no bypass.
    cycle(32'h80, 1'b1, 32'h80, 1'b1, 32'h200, 1'b0, 32'h84, 1'b0);
    lookup("after_same", 32'h80, 1'b1, 32'h200);

    // Flush coinciding with an update.
    cycle(32'h0, 1'b1, 32'hC0, 1'b1, 32'h300, 1'b0, 32'hC4, 1'b1);
    lookup("flush_80", 32'h80, 1'b0, 32'h84);
    lookup("flush_c0", 32'hC0, 1'b0, 32'hC4);
    lookup("flush_440", 32'h440, 1'b0, 32'h444);

    // Not-taken redirect target wraps.
    cycle(32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h8, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      logic        mt;
      logic [31:0] mtgt;
      if ($urandom_range(0, 99) == 0) begin
        do_reset(rand_pc());
      end else begin
        lk   = rand_pc();
        upc  = rand_pc();
        uv   = ($urandom_range(0, 3) != 0);
        ut   = $urandom_range(0, 1) == 1;
        utgt = 32'($urandom_range(0, 7)) << 4;
        model_lookup(upc, mt, mtgt);
        if ($urandom_range(0, 3) != 0) begin
          upt   = mt;
          uptgt = mtgt;
        end else begin
          upt   = $urandom_range(0, 1) == 1;
          uptgt = 32'($urandom_range(0, 7)) << 4;
        end
        fl = ($urandom_range(0, 31) == 0);
        if ($urandom_range(0, 1) == 1) lk = upc;
        cycle(lk, uv, upc, ut, utgt, upt, uptgt, fl);
      end
    end

    // Five updates, two mispredicts, then reset clears everything.
    do_reset(32'h100);
    cycle(32'h0, 1'b1, 32'h100, 1'b1, 32'h300, 1'b0, 32'h104, 1'b0);
    cycle(32'h0, 1'b1, 32'h100, 1'b1, 32'h300, 1'b1, 32'h300, 1'b0);
    cycle(32'h0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h104, 1'b0);
    cycle(32'h0, 1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 32'h108, 1'b0);
    cycle(32'h0, 1'b1, 32'h100, 1'b1, 32'h304, 1'b1, 32'h300, 1'b0);
`ifdef BRANCH_PREDICTOR_STATS_EN
    check("stat5_branches", stat_branches_o, 32'd5);
    check("stat5_mispredicts", stat_mispredicts_o, 32'd2);
`endif
    lookup("pre_rst", 32'h100, 1'b1, 32'h304);
    do_reset(32'h100);
    lookup("post_rst_100", 32'h100, 1'b0, 32'h104);
    lookup("post_rst_40", 32'h40, 1'b0, 32'h44);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
